reset_responder: RTL and testbench

- Responder end of the software-reset handshake issued by the processor control block.
- Accepts a one-cycle software reset request carrying a 4-bit vector: [3] Full, [2] Inst, [1] IO, [0] Data.
- Drives the per-domain reset lines for a fixed hold time, waits for the IO and Data domains to report completion, then returns a single-cycle reset response.
- Sits between processor control and the instruction, IO and data subsystems.

---
 rtl/reset_responder.sv | 166 ++++++++++++++++
 tb/tb_reset_responder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reset_responder.sv
// Software-reset responder: holds the requested domain resets, collects
// IO/Data completion acks (with timeout), then pulses a single response.
module reset_responder #(
  parameter int RESET_HOLD_CYCLES  = 4,
  parameter int ACK_TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       clk_en,
  input  logic       sync_rst,
  input  logic       SoftwareResetIn,
  input  logic [3:0] ResetVectorIn,
  output logic       ResetResponseOut,
  output logic       SystemResetOut,
  output logic       InstResetOut,
  output logic       IOResetOut,
  output logic       DataResetOut,
  input  logic       IOResetDoneIn,
  input  logic       DataResetDoneIn,
  output logic       Busy,
  output logic       TimeoutFlag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_FULL,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] HOLD_LD = 8'(RESET_HOLD_CYCLES - 1);
  localparam logic [7:0] TMO_LD  = 8'(ACK_TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_vec;
  logic [7:0] r_hold;
  logic [7:0] r_tmo;
  logic       r_io_done;
  logic       r_data_done;
  logic       r_tflag;
  logic       r_resp;
  logic       r_sys;
  logic       r_inst;
  logic       r_io;
  logic       r_data;
  logic       r_busy;

  logic       w_io_ok;
  logic       w_data_ok;

  // An unrequested domain is treated as already done.
  assign w_io_ok   = r_io_done | IOResetDoneIn | ~r_vec[1];
  assign w_data_ok = r_data_done | DataResetDoneIn | ~r_vec[0];

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state     <= S_IDLE;
      r_vec       <= '0;
      r_hold      <= '0;
      r_tmo       <= '0;
      r_io_done   <= 1'b0;
      r_data_done <= 1'b0;
      r_tflag     <= 1'b0;
      r_resp      <= 1'b0;
      r_sys       <= 1'b0;
      r_inst      <= 1'b0;
      r_io        <= 1'b0;
      r_data      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (clk_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (SoftwareResetIn) begin
            r_vec       <= ResetVectorIn;
            r_hold      <= HOLD_LD;
            r_io_done   <= 1'b0;
            r_data_done <= 1'b0;
            if (ResetVectorIn[3]) begin
              r_state <= S_FULL;
              r_sys   <= 1'b1;
              r_inst  <= 1'b1;
              r_io    <= 1'b1;
              r_data  <= 1'b1;
              r_busy  <= 1'b1;
            end else if (|ResetVectorIn[2:0]) begin
              r_state <= S_ASSERT;
              r_inst  <= ResetVectorIn[2];
              r_io    <= ResetVectorIn[1];
              r_data  <= ResetVectorIn[0];
              r_busy  <= 1'b1;
            end
          end
        end
        S_ASSERT: begin
          if (r_hold == 8'd0) begin
            r_inst <= 1'b0;
            r_io   <= 1'b0;
            r_data <= 1'b0;
            r_tmo  <= TMO_LD;
            if (r_vec[1] | r_vec[0]) begin
              r_state <= S_WAIT;
            end else begin
              r_state <= S_RESP;
              r_resp  <= 1'b1;
            end
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        S_FULL: begin
          if (r_hold == 8'd0) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_sys   <= 1'b0;
            r_inst  <= 1'b0;
            r_io    <= 1'b0;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        S_WAIT: begin
          r_io_done   <= r_io_done | IOResetDoneIn;
          r_data_done <= r_data_done | DataResetDoneIn;
          if (w_io_ok && w_data_ok) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
          end else if (r_tmo == 8'd0) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
            r_tflag <= 1'b1;
          end else begin
            r_tmo <= r_tmo - 8'd1;
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_resp      <= 1'b0;
          r_busy      <= 1'b0;
          r_vec       <= '0;
          r_io_done   <= 1'b0;
          r_data_done <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_resp  <= 1'b0;
          r_sys   <= 1'b0;
          r_inst  <= 1'b0;
          r_io    <= 1'b0;
          r_data  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ResetResponseOut = r_resp;
  assign SystemResetOut   = r_sys;
  assign InstResetOut     = r_inst;
  assign IOResetOut       = r_io;
  assign DataResetOut     = r_data;
  assign Busy             = r_busy;
  assign TimeoutFlag      = r_tflag;

endmodule

// File: tb/tb_reset_responder.sv
// Bench for reset_responder: directed plan scenarios plus random traffic,
// checked every cycle against an elapsed-cycle transaction model.
module tb_reset_responder;

  localparam int H = 4;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       sync_rst = 1'b1;
  logic       req = 1'b0;
  logic [3:0] vec = 4'd0;
  logic       iod = 1'b0;
  logic       dd = 1'b0;
  logic       resp, sys, inst, io, data, busy, tflag;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  reset_responder #(
    .RESET_HOLD_CYCLES(H),
    .ACK_TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .clk_en(clk_en),
    .sync_rst(sync_rst),
    .SoftwareResetIn(req),
    .ResetVectorIn(vec),
    .ResetResponseOut(resp),
    .SystemResetOut(sys),
    .InstResetOut(inst),
    .IOResetOut(io),
    .DataResetOut(data),
    .IOResetDoneIn(iod),
    .DataResetDoneIn(dd),
    .Busy(busy),
    .TimeoutFlag(tflag)
  );

  always #5 clk = ~clk;

  // Model: m_k counts enabled edges since acceptance; m_resp is the
  // k value during which the response is visible (0 = not yet known).
  bit       m_act = 1'b0;
  bit [3:0] m_vec = 4'd0;
  int       m_k = 0;
  int       m_resp = 0;
  bit       m_io = 1'b0;
  bit       m_da = 1'b0;
  bit       m_tf = 1'b0;

  always @(posedge clk) begin
    bit       nact, nio, nda, ntf;
    bit [3:0] nvec;
    int       nk, nresp;
    nact = m_act; nvec = m_vec; nk = m_k; nresp = m_resp;
    nio = m_io; nda = m_da; ntf = m_tf;
    if (sync_rst) begin
      nact = 1'b0; nk = 0; nresp = 0; ntf = 1'b0; nvec = 4'd0;
    end else if (clk_en) begin
      if (!m_act) begin
        if (req && vec != 4'd0) begin
          nact = 1'b1; nvec = vec; nk = 1; nio = 1'b0; nda = 1'b0;
          nresp = (!vec[3] && vec[1:0] == 2'b00) ? H + 1 : 0;
        end
      end else begin
        if (!m_vec[3] && m_vec[1:0] != 2'b00 && m_resp == 0 && m_k > H) begin
          nio = m_io | iod;
          nda = m_da | dd;
          if ((nio || !m_vec[1]) && (nda || !m_vec[0])) nresp = m_k + 1;
          else if (m_k == H + T) begin
            nresp = m_k + 1;
            ntf = 1'b1;
          end
        end
        if ((m_vec[3] && m_k == H) || (m_resp != 0 && m_k == m_resp))
          nact = 1'b0;
        nk = m_k + 1;
      end
    end
    m_act <= nact; m_vec <= nvec; m_k <= nk; m_resp <= nresp;
    m_io <= nio; m_da <= nda; m_tf <= ntf;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_outs();
    bit dom;
    dom = m_act && m_k <= H;
    return {dom && m_vec[3],
            dom && (m_vec[3] | m_vec[2]),
            dom && (m_vec[3] | m_vec[1]),
            dom && (m_vec[3] | m_vec[0]),
            m_act && m_resp != 0 && m_k == m_resp,
            m_act,
            m_tf};
  endfunction

  // Check the previous edge's result, then drive the next cycle's inputs.
  task automatic cyc(input logic en, input logic r, input logic [3:0] v,
                     input logic a_io, input logic a_d, input logic rst);
    @(negedge clk);
    chk($sformatf("outs@%0d", cyc_n),
        {25'd0, sys, inst, io, data, resp, busy, tflag}, {25'd0, model_outs()});
    cyc_n++;
    clk_en = en; req = r; vec = v; iod = a_io; dd = a_d; sync_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 4'd0, 0, 0, 1);
    cyc(1, 0, 4'd0, 0, 0, 1);
    idle(2);
    // Inst only
    cyc(1, 1, 4'b0100, 0, 0, 0);
    idle(8);
    // IO + Data, acks at cycles 7 and 9
    cyc(1, 1, 4'b0011, 0, 0, 0);
    for (int i = 1; i < 14; i++) cyc(1, 0, 4'd0, i == 7, i == 9, 0);
    // IO timeout, then ack on the last wait cycle
    cyc(1, 1, 4'b0010, 0, 0, 0);
    for (int i = 1; i < 25; i++) cyc(1, 0, 4'd0, 0, 0, 0);
    cyc(1, 0, 4'd0, 0, 0, 1);
    cyc(1, 1, 4'b0010, 0, 0, 0);
    for (int i = 1; i < 25; i++) cyc(1, 0, 4'd0, i == 20, 0, 0);
    // Full, zero vector, dropped second request
    cyc(1, 1, 4'b1000, 0, 0, 0);
    idle(7);
    cyc(1, 1, 4'b0000, 0, 0, 0);
    idle(3);
    cyc(1, 1, 4'b0100, 0, 0, 0);
    for (int i = 1; i < 10; i++) cyc(1, i == 2, 4'b0001, 0, 0, 0);
    // clk_en gating
    cyc(1, 1, 4'b0100, 0, 0, 0);
    for (int i = 1; i < 20; i++) cyc(logic'(i % 2), 0, 4'd0, 0, 0, 0);
    idle(2);
    // Mid-operation reset
    cyc(1, 1, 4'b0010, 0, 0, 0);
    for (int i = 1; i < 30; i++) cyc(1, 0, 4'd0, i == 8, 0, i == 3);
    // Random traffic
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
          4'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
